// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : fetch FSM states (BOOT, RUN, STALL, FLUSH)
//   npc_sel_t     : which source produced the next PC this cycle
//   TEXT_BASE_DEFAULT : PC value after reset
//   NOP_INSTR     : encoding loaded into IF/ID for a bubble
//   align_word()  : clears the byte-offset bits of a target address
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_JR   = 3'd1,
        SEL_J    = 3'd2,
        SEL_BR   = 3'd3,
        SEL_SEQ  = 3'd4
    } npc_sel_t;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the ID-stage requests, program-memory data and IF/ID outputs of the
// fetch sequencer.
//   master : the fetch sequencer (drives PC, IF/ID, pulses and counters)
//   slave  : the surrounding ID stage / program memory
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int NBits    = 32,
    parameter int CNT_BITS = 16
);
    logic                Stall_i;
    logic                Branch_Taken_i;
    logic [NBits-1:0]    Branch_Target_i;
    logic                Jump_i;
    logic [NBits-1:0]    Jump_Target_i;
    logic                JumpReg_i;
    logic [NBits-1:0]    JumpReg_Target_i;
    logic [NBits-1:0]    Instruction_i;

    logic [NBits-1:0]    PC_o;
    logic [NBits-1:0]    IFID_Instruction_o;
    logic [NBits-1:0]    IFID_PC_4_o;
    logic                IFID_Valid_o;
    logic                Redirect_o;
    logic                Misalign_o;
    logic [CNT_BITS-1:0] Stall_Count_o;
    logic [CNT_BITS-1:0] Flush_Count_o;

    modport master (
        input  Stall_i, Branch_Taken_i, Branch_Target_i, Jump_i, Jump_Target_i,
               JumpReg_i, JumpReg_Target_i, Instruction_i,
        output PC_o, IFID_Instruction_o, IFID_PC_4_o, IFID_Valid_o,
               Redirect_o, Misalign_o, Stall_Count_o, Flush_Count_o
    );

    modport slave (
        output Stall_i, Branch_Taken_i, Branch_Target_i, Jump_i, Jump_Target_i,
               JumpReg_i, JumpReg_Target_i, Instruction_i,
        input  PC_o, IFID_Instruction_o, IFID_PC_4_o, IFID_Valid_o,
               Redirect_o, Misalign_o, Stall_Count_o, Flush_Count_o
    );
endinterface

// File: rtl/adder32bits.sv
// -----------------------------------------------------------------------------
// Adder32bits
// Plain modulo-2^NBits adder used for the PC+4 increment.
//   data0, data1 : operands
//   result       : data0 + data1, carry discarded
// -----------------------------------------------------------------------------
module Adder32bits #(
    parameter int NBits = 32
) (
    input  logic [NBits-1:0] data0,
    input  logic [NBits-1:0] data1,
    output logic [NBits-1:0] result
);
    assign result = data0 + data1;
endmodule

// File: rtl/fetch_sequencer_next_pc_select.sv
// -----------------------------------------------------------------------------
// next_pc_select
// Combinational next-PC priority mux: stall > JR > J > taken branch > PC+4.
//   stall, jump_reg, jump, branch_taken : requests from ID
//   jr_target, j_target, br_target      : raw target byte addresses
//   pc, pc_plus4                        : current PC and its increment
//   next_pc  : PC for the next edge (redirect targets word-aligned)
//   redirect : a redirect is accepted this cycle
//   misalign : the accepted target had nonzero low bits
// -----------------------------------------------------------------------------
module next_pc_select
    import fetch_pkg::*;
#(
    parameter int NBits = 32
) (
    input  logic             stall,
    input  logic             jump_reg,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic [NBits-1:0] jr_target,
    input  logic [NBits-1:0] j_target,
    input  logic [NBits-1:0] br_target,
    input  logic [NBits-1:0] pc,
    input  logic [NBits-1:0] pc_plus4,
    output logic [NBits-1:0] next_pc,
    output logic             redirect,
    output logic             misalign
);
    npc_sel_t         sel;
    logic [NBits-1:0] raw_target;

    always_comb begin
        sel = SEL_SEQ;
        if (stall)             sel = SEL_HOLD;
        else if (jump_reg)     sel = SEL_JR;
        else if (jump)         sel = SEL_J;
        else if (branch_taken) sel = SEL_BR;
    end

    always_comb begin
        raw_target = pc_plus4;
        case (sel)
            SEL_JR:  raw_target = jr_target;
            SEL_J:   raw_target = j_target;
            SEL_BR:  raw_target = br_target;
            default: raw_target = pc_plus4;
        endcase
    end

    assign redirect = (sel == SEL_JR) || (sel == SEL_J) || (sel == SEL_BR);
    assign misalign = redirect && (raw_target[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        if (sel == SEL_HOLD)
            next_pc = pc;
        else if (redirect)
            next_pc = {raw_target[NBits-1:2], 2'b00};
    end
endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter and the IF/ID pipeline register of the MIPS core.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : master side of fetch_sequencer_if (ID requests in, PC / IF/ID /
//           redirect pulses / saturating stall and flush counters out)
// A stall freezes PC and IF/ID; an accepted redirect loads the word-aligned
// target into PC and squashes the instruction fetched in the same cycle.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          NBits     = 32,
    parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT,
    parameter int          CNT_BITS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam logic [NBits-1:0]    PC_STEP = NBits'(4);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [NBits-1:0]    pc_reg;
    logic [NBits-1:0]    pc_plus4;
    logic [NBits-1:0]    next_pc;
    logic                redirect;
    logic                misalign;
    logic [NBits-1:0]    ifid_instr_reg;
    logic [NBits-1:0]    ifid_pc4_reg;
    logic                ifid_valid_reg;
    logic [CNT_BITS-1:0] stall_cnt_reg;
    logic [CNT_BITS-1:0] flush_cnt_reg;
    fetch_state_t        state_reg;
    fetch_state_t        state_next;

    Adder32bits #(.NBits(NBits)) u_pc_adder (
        .data0  (pc_reg),
        .data1  (PC_STEP),
        .result (pc_plus4)
    );

    next_pc_select #(.NBits(NBits)) u_next_pc (
        .stall        (bus.Stall_i),
        .jump_reg     (bus.JumpReg_i),
        .jump         (bus.Jump_i),
        .branch_taken (bus.Branch_Taken_i),
        .jr_target    (bus.JumpReg_Target_i),
        .j_target     (bus.Jump_Target_i),
        .br_target    (bus.Branch_Target_i),
        .pc           (pc_reg),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .redirect     (redirect),
        .misalign     (misalign)
    );

    // Every state leaves by the same rule: stall wins, then redirect, else run.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT, RUN, FLUSH, STALL: begin
                if (bus.Stall_i)   state_next = STALL;
                else if (redirect) state_next = FLUSH;
                else               state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg         <= TEXT_BASE[NBits-1:0];
            ifid_instr_reg <= '0;
            ifid_pc4_reg   <= '0;
            ifid_valid_reg <= 1'b0;
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
            state_reg      <= BOOT;
        end else begin
            state_reg <= state_next;
            pc_reg    <= next_pc;
            if (bus.Stall_i) begin
                ifid_instr_reg <= ifid_instr_reg;
                ifid_pc4_reg   <= ifid_pc4_reg;
                ifid_valid_reg <= ifid_valid_reg;
            end else if (redirect) begin
                ifid_instr_reg <= NOP_INSTR[NBits-1:0];
                ifid_pc4_reg   <= '0;
                ifid_valid_reg <= 1'b0;
            end else begin
                ifid_instr_reg <= bus.Instruction_i;
                ifid_pc4_reg   <= pc_plus4;
                ifid_valid_reg <= 1'b1;
            end
            if (bus.Stall_i && (stall_cnt_reg != CNT_MAX))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (redirect && (flush_cnt_reg != CNT_MAX))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign bus.PC_o               = pc_reg;
    assign bus.IFID_Instruction_o = ifid_instr_reg;
    assign bus.IFID_PC_4_o        = ifid_pc4_reg;
    assign bus.IFID_Valid_o       = ifid_valid_reg;
    // The pulses are combinational; gate them so they read 0 while in reset.
    assign bus.Redirect_o         = redirect & reset;
    assign bus.Misalign_o         = misalign & reset;
    assign bus.Stall_Count_o      = stall_cnt_reg;
    assign bus.Flush_Count_o      = flush_cnt_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed-vector bench for fetch_sequencer. Program memory returns
// {16'hC0DE, PC[15:0]} so the expected IF/ID instruction follows from the PC.
// A second instance with 2-bit counters exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cycle;

    fetch_sequencer_if #(.NBits(32), .CNT_BITS(16)) bus ();
    fetch_sequencer_if #(.NBits(32), .CNT_BITS(2))  sat_bus ();

    fetch_sequencer #(.NBits(32), .TEXT_BASE(32'h0040_0000), .CNT_BITS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_sequencer #(.NBits(32), .TEXT_BASE(32'h0040_0000), .CNT_BITS(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_bus)
    );

    assign bus.Instruction_i     = {16'hC0DE, bus.PC_o[15:0]};
    assign sat_bus.Instruction_i = {16'hC0DE, sat_bus.PC_o[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        $display("cycle %0d pc=%08h ifid_pc4=%08h valid=%0b stall_cnt=%0d flush_cnt=%0d",
                 cycle, bus.PC_o, bus.IFID_PC_4_o, bus.IFID_Valid_o,
                 bus.Stall_Count_o, bus.Flush_Count_o);
    endtask

    task automatic clear_req();
        bus.Stall_i = 0; bus.Branch_Taken_i = 0; bus.Jump_i = 0; bus.JumpReg_i = 0;
        bus.Branch_Target_i = 0; bus.Jump_Target_i = 0; bus.JumpReg_Target_i = 0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check_value({tag, "_instr"}, bus.IFID_Instruction_o, instr);
        check_value({tag, "_pc4"},   bus.IFID_PC_4_o, pc4);
        check_value({tag, "_valid"}, 32'(bus.IFID_Valid_o), 32'(valid));
    endtask

    initial begin
        checks = 0; failures = 0; cycle = 0;
        reset = 1'b0;
        clear_req();
        sat_bus.Stall_i = 0; sat_bus.Branch_Taken_i = 0; sat_bus.Jump_i = 0;
        sat_bus.JumpReg_i = 0; sat_bus.Branch_Target_i = 0;
        sat_bus.Jump_Target_i = 0; sat_bus.JumpReg_Target_i = 0;

        repeat (2) @(posedge clk);
        #1;
        check_value("rst_pc", bus.PC_o, 32'h0040_0000);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check_value("rst_stall_cnt", 32'(bus.Stall_Count_o), 32'd0);
        check_value("rst_flush_cnt", 32'(bus.Flush_Count_o), 32'd0);
        check_value("rst_redirect", 32'(bus.Redirect_o), 32'd0);
        reset = 1'b1;

        // Sequential fetch from TEXT_BASE
        step();
        check_value("seq1_pc", bus.PC_o, 32'h0040_0004);
        check_ifid("seq1", 32'hC0DE_0000, 32'h0040_0004, 1'b1);
        step();
        check_value("seq2_pc", bus.PC_o, 32'h0040_0008);
        step();
        check_value("seq3_pc", bus.PC_o, 32'h0040_000C);
        check_ifid("seq3", 32'hC0DE_0008, 32'h0040_000C, 1'b1);

        // Taken branch at 0x0040000C
        bus.Branch_Taken_i = 1; bus.Branch_Target_i = 32'h0040_0040;
        #1;
        check_value("br_redirect", 32'(bus.Redirect_o), 32'd1);
        check_value("br_misalign", 32'(bus.Misalign_o), 32'd0);
        step();
        clear_req();
        #1;
        check_value("br_pc", bus.PC_o, 32'h0040_0040);
        check_ifid("br_bubble", 32'h0, 32'h0, 1'b0);
        check_value("br_flush_cnt", 32'(bus.Flush_Count_o), 32'd1);
        check_value("br_redirect_off", 32'(bus.Redirect_o), 32'd0);
        step();
        check_value("br_next_pc", bus.PC_o, 32'h0040_0044);
        check_ifid("br_next", 32'hC0DE_0040, 32'h0040_0044, 1'b1);

        // Stall for 3 cycles with a jump pending
        bus.Stall_i = 1; bus.Jump_i = 1; bus.Jump_Target_i = 32'h0040_0080;
        #1;
        check_value("stall_redirect_masked", 32'(bus.Redirect_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("stall_pc", bus.PC_o, 32'h0040_0044);
            check_ifid("stall", 32'hC0DE_0040, 32'h0040_0044, 1'b1);
            check_value("stall_cnt_run", 32'(bus.Stall_Count_o), 32'(i + 1));
        end
        bus.Stall_i = 0;
        #1;
        check_value("jump_redirect", 32'(bus.Redirect_o), 32'd1);
        step();
        clear_req();
        check_value("jump_pc", bus.PC_o, 32'h0040_0080);
        check_value("jump_stall_cnt", 32'(bus.Stall_Count_o), 32'd3);
        check_value("jump_flush_cnt", 32'(bus.Flush_Count_o), 32'd2);
        check_value("jump_bubble_valid", 32'(bus.IFID_Valid_o), 32'd0);
        step();
        check_value("jump_next_pc", bus.PC_o, 32'h0040_0084);
        check_ifid("jump_next", 32'hC0DE_0080, 32'h0040_0084, 1'b1);

        // JR, J and branch together: JR wins, misaligned target
        bus.JumpReg_i = 1; bus.JumpReg_Target_i = 32'h0040_0103;
        bus.Jump_i = 1; bus.Jump_Target_i = 32'h0040_0200;
        bus.Branch_Taken_i = 1; bus.Branch_Target_i = 32'h0040_0300;
        #1;
        check_value("jr_redirect", 32'(bus.Redirect_o), 32'd1);
        check_value("jr_misalign", 32'(bus.Misalign_o), 32'd1);
        step();
        clear_req();
        #1;
        check_value("jr_pc", bus.PC_o, 32'h0040_0100);
        check_value("jr_flush_cnt", 32'(bus.Flush_Count_o), 32'd3);
        check_value("jr_misalign_off", 32'(bus.Misalign_o), 32'd0);

        // Back-to-back redirect while the bubble is in ID
        bus.Jump_i = 1; bus.Jump_Target_i = 32'h0040_0010;
        #1;
        check_value("b2b_redirect", 32'(bus.Redirect_o), 32'd1);
        step();
        clear_req();
        check_value("b2b_pc", bus.PC_o, 32'h0040_0010);
        check_value("b2b_flush_cnt", 32'(bus.Flush_Count_o), 32'd4);
        check_value("b2b_valid", 32'(bus.IFID_Valid_o), 32'd0);

        // Jump + branch together: jump wins, single flush increment
        bus.Jump_i = 1; bus.Jump_Target_i = 32'hFFFF_FFFC;
        bus.Branch_Taken_i = 1; bus.Branch_Target_i = 32'h0040_0300;
        step();
        clear_req();
        check_value("wrap_jump_pc", bus.PC_o, 32'hFFFF_FFFC);
        check_value("wrap_flush_cnt", 32'(bus.Flush_Count_o), 32'd5);
        step();
        check_value("wrap_pc", bus.PC_o, 32'h0000_0000);
        check_ifid("wrap", 32'hC0DE_FFFC, 32'h0000_0000, 1'b1);

        // Reset mid-stall with a redirect pending
        bus.Stall_i = 1; bus.Branch_Taken_i = 1; bus.Branch_Target_i = 32'h0040_0040;
        step();
        check_value("pre_rst_stall_cnt", 32'(bus.Stall_Count_o), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        check_value("async_rst_pc", bus.PC_o, 32'h0040_0000);
        check_ifid("async_rst", 32'h0, 32'h0, 1'b0);
        check_value("async_rst_stall_cnt", 32'(bus.Stall_Count_o), 32'd0);
        check_value("async_rst_flush_cnt", 32'(bus.Flush_Count_o), 32'd0);
        bus.Stall_i = 0;
        #1;
        check_value("async_rst_redirect", 32'(bus.Redirect_o), 32'd0);
        step();
        check_value("in_rst_pc", bus.PC_o, 32'h0040_0000);
        clear_req();
        reset = 1'b1;
        step();
        check_value("restart_pc", bus.PC_o, 32'h0040_0004);
        check_ifid("restart", 32'hC0DE_0000, 32'h0040_0004, 1'b1);

        // Saturation on the 2-bit counter instance
        sat_bus.Stall_i = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_value("sat_stall_cnt", 32'(sat_bus.Stall_Count_o), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        sat_bus.Stall_i = 0;
        check_value("sat_pc_frozen", sat_bus.PC_o, 32'h0040_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls instruction fetch for the pipelined MIPS core.
- Owns the program counter and the IF/ID pipeline register.
- Each cycle, chooses the next PC from sequential, branch, jump and jump-register sources.
- Handles load-use stalls and wrong-path flushes, and keeps saturating stall/flush counters.
- Sits between the program memory (which it drives with the PC) and the ID stage (which supplies the hazard and redirect requests).

## Interface
- NBits, 32, datapath width
- TEXT_BASE, 32'h0040_0000, PC value after reset
- CNT_BITS, 16, width of the performance counters
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- Stall_i  in  1  load-use hazard from ID; hold PC and IF/ID
- Branch_Taken_i  in  1  conditional branch resolved taken in ID
- Branch_Target_i  in  NBits  branch target byte address
- Jump_i  in  1  J/JAL decoded in ID
- Jump_Target_i  in  NBits  jump target byte address
- JumpReg_i  in  1  JR decoded in ID
- JumpReg_Target_i  in  NBits  register value for JR
- Instruction_i  in  NBits  program-memory data for PC_o (combinational read)
- PC_o  out  NBits  current fetch PC, registered
- IFID_Instruction_o  out  NBits  instruction held for ID
- IFID_PC_4_o  out  NBits  PC+4 of the held instruction
- IFID_Valid_o  out  1  IF/ID holds a real instruction
- Redirect_o  out  1  one-cycle pulse: redirect accepted this cycle
- Misalign_o  out  1  one-cycle pulse: accepted target had bits [1:0] ≠ 0
- Stall_Count_o  out  CNT_BITS  saturating count of stall cycles
- Flush_Count_o  out  CNT_BITS  saturating count of accepted redirects

## Operation
- **Next-PC priority** (combinational, evaluated each cycle):
  1. Stall_i
  2. JumpReg_i
  3. Jump_i
  4. Branch_Taken_i
  5. PC_o+4
- Stall_i masks all redirect inputs. A branch or JR waiting on a load is not yet resolved, so it is re-presented after the stall.
- Accepted target: bits [1:0] are forced to 0. Misalign_o = OR of the discarded bits, only on the cycle the redirect is accepted.
- No branch delay slot. On a redirect, the instruction fetched in the same cycle is wrong-path and is squashed.
- IF/ID load rule per edge:
  - Stall: hold all IF/ID fields.
  - Redirect: load a bubble (instruction 0, PC_4 0, valid 0).
  - Otherwise: load Instruction_i, PC_o+4, valid 1.
- **State machine**, with next state taken from the inputs in the current cycle:
  - BOOT (reset state): IF/ID invalid.
    - Stall_i → STALL
    - accepted redirect → FLUSH
    - otherwise → RUN
  - RUN: normal fetch; same transitions as BOOT.
  - STALL: PC and IF/ID frozen; Stall_Count increments each stall cycle.
    - Stall_i stays high → STALL
    - otherwise the next state follows the redirect/sequential rules.
  - FLUSH: IF/ID holds a bubble; the fetch at the new target proceeds.
    - Transitions as from RUN. A back-to-back redirect (bubble still in ID) is legal and accepted.
- Counters:
  - Stall_Count increments on every edge with Stall_i=1.
  - Flush_Count increments on every accepted redirect.
  - Both saturate at all-ones and never wrap.
- PC arithmetic is modulo 2^NBits. PC 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset values:
  - PC_o = TEXT_BASE
  - IFID_Instruction_o = 0, IFID_PC_4_o = 0, IFID_Valid_o = 0
  - Redirect_o = 0, Misalign_o = 0
  - counters = 0, state = BOOT

## Timing
- Redirect accepted in cycle n: PC_o = target at n+1; IF/ID bubble at n+1; Redirect_o high in cycle n (combinational from the accepted request).
- Stall in cycle n: PC_o and IF/ID at n+1 equal their values at n.
- Redirect penalty is 1 bubble; stall penalty is 1 cycle per Stall_i cycle.
- First real instruction (from TEXT_BASE) appears in IF/ID one edge after reset deassertion.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously); pending stall and redirect are discarded.
- Simultaneous Jump_i and Branch_Taken_i: jump wins; only one Flush_Count increment.

## Structure
- Package fetch_pkg holds:
  - state enum (BOOT, RUN, STALL, FLUSH)
  - TEXT_BASE default
  - NOP encoding 32'h0000_0000
  - next-PC select encoding
- Sub-module next_pc_select: combinational priority mux, target alignment and misalign detect.
- PC+4 comes from an existing Adder32bits instance.

## Test plan
- Reset release, no hazards: PC_o steps 0x00400000, 0x00400004, 0x00400008. IF/ID valid from edge 1, with IFID_PC_4_o = 0x00400004.
- Branch_Taken_i=1 with target 0x00400040 at PC 0x0040000C: next PC_o = 0x00400040, IF/ID bubble for 1 cycle, Redirect_o pulses, Flush_Count = 1.
- Stall_i high for 3 cycles together with Jump_i=1: PC_o and IF/ID frozen for 3 cycles; jump accepted only after Stall_i drops; Stall_Count = 3.
- JumpReg_i, Jump_i and Branch_Taken_i asserted together, with JR target 0x00400103: PC_o = 0x00400100, Misalign_o pulses.
- Preload Stall_Count at 0xFFFE and hold Stall_i for 5 cycles: count ends at 0xFFFF.
- Assert reset mid-stall with a redirect pending: outputs go to reset values asynchronously; after release, fetch restarts at 0x00400000.
